// File: rtl/lstm_acc_pkg.sv
// Register map and FSM state encoding shared by the LSTM accelerator stream master
// and the accelerator's device-side register slave.
package lstm_acc_pkg;

    localparam logic [31:0] OFF_DATA_IN  = 32'h0000_0004;
    localparam logic [31:0] OFF_OUT_BASE = 32'h0000_0048;
    localparam logic [31:0] OFF_R_VALID  = 32'h0000_0058;
    localparam logic [31:0] OFF_IS_LAST  = 32'h0000_005C;
    localparam logic [31:0] OFF_W_VALID  = 32'h0000_0064;

    localparam logic [3:0]  BE_ALL       = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_RV,
        ST_MRD,
        ST_AWR,
        ST_SET_LAST,
        ST_POLL,
        ST_ARD,
        ST_MWR,
        ST_CLR_LAST,
        ST_CLR_RV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lstm_stream_master_if.sv
// Simple req/gnt bus with a separate read/write-completion strobe; used for both the
// memory port and the accelerator register port of the stream master.
interface lstm_stream_master_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lstm_stream_master.sv
// Bus initiator that streams input words into the LSTM accelerator, optionally closes
// the timestep gate, polls for results and copies them back to memory.
module lstm_stream_master
    import lstm_acc_pkg::*;
#(
    parameter logic [31:0] ACC_BASE   = 32'h0,
    parameter int unsigned OUT_WORDS  = 8,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [31:0]                 src_addr_i,
    input  logic [31:0]                 dst_addr_i,
    input  logic [15:0]                 n_words_i,
    input  logic                        last_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    lstm_stream_master_if.master        mem,
    lstm_stream_master_if.master        acc
);

    localparam int unsigned    PCW          = $clog2(POLL_LIMIT + 1);
    localparam logic [15:0]    OUT_WORDS_W  = 16'(OUT_WORDS);
    localparam logic [PCW-1:0] POLL_LIMIT_W = PCW'(POLL_LIMIT);

    state_e         state_q, state_d;
    logic           wait_q, wait_d;
    logic [15:0]    i_q, i_d;
    logic [15:0]    k_q, k_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic           err_q, err_d;

    logic [31:0]    src_q, src_d;
    logic [31:0]    dst_q, dst_d;
    logic [15:0]    n_q, n_d;
    logic           last_q, last_d;
    logic [31:0]    buf_q, buf_d;

    logic [15:0]    i_inc;
    logic [15:0]    k_inc;
    logic [PCW-1:0] poll_inc;
    state_e         after_in;

    assign i_inc    = i_q + 16'd1;
    assign k_inc    = k_q + 16'd1;
    assign poll_inc = poll_q + PCW'(1);
    assign after_in = last_q ? ST_SET_LAST : ST_CLR_RV;

    assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;

    // wait_q marks a granted transaction whose completion strobe is still outstanding;
    // req is dropped meanwhile so each port never has more than one transaction in flight.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        i_d       = i_q;
        k_d       = k_q;
        poll_d    = poll_q;
        err_d     = err_q;
        src_d     = src_q;
        dst_d     = dst_q;
        n_d       = n_q;
        last_d    = last_q;
        buf_d     = buf_q;
        mem.req   = 1'b0;
        mem.we    = 1'b0;
        mem.be    = 4'h0;
        mem.addr  = 32'h0;
        mem.wdata = 32'h0;
        acc.req   = 1'b0;
        acc.we    = 1'b0;
        acc.be    = 4'h0;
        acc.addr  = 32'h0;
        acc.wdata = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    n_d     = n_words_i;
                    last_d  = last_i;
                    err_d   = 1'b0;
                    i_d     = 16'd0;
                    k_d     = 16'd0;
                    poll_d  = '0;
                    wait_d  = 1'b0;
                    state_d = ST_SET_RV;
                end
            end

            ST_SET_RV: begin
                acc.req   = 1'b1;
                acc.we    = 1'b1;
                acc.be    = BE_ALL;
                acc.addr  = ACC_BASE + OFF_R_VALID;
                acc.wdata = 32'd1;
                if (acc.gnt) state_d = (n_q == 16'd0) ? after_in : ST_MRD;
            end

            ST_MRD: begin
                if (!wait_q) begin
                    mem.req  = 1'b1;
                    mem.be   = BE_ALL;
                    mem.addr = src_q + {14'd0, i_q, 2'b00};
                    if (mem.gnt) wait_d = 1'b1;
                end else if (mem.rvalid) begin
                    wait_d  = 1'b0;
                    buf_d   = mem.rdata;
                    state_d = ST_AWR;
                end
            end

            ST_AWR: begin
                acc.req   = 1'b1;
                acc.we    = 1'b1;
                acc.be    = BE_ALL;
                acc.addr  = ACC_BASE + OFF_DATA_IN;
                acc.wdata = buf_q;
                if (acc.gnt) begin
                    i_d     = i_inc;
                    state_d = (i_inc == n_q) ? after_in : ST_MRD;
                end
            end

            ST_SET_LAST: begin
                acc.req   = 1'b1;
                acc.we    = 1'b1;
                acc.be    = BE_ALL;
                acc.addr  = ACC_BASE + OFF_IS_LAST;
                acc.wdata = 32'd1;
                if (acc.gnt) state_d = ST_POLL;
            end

            ST_POLL: begin
                if (!wait_q) begin
                    acc.req  = 1'b1;
                    acc.be   = BE_ALL;
                    acc.addr = ACC_BASE + OFF_W_VALID;
                    if (acc.gnt) wait_d = 1'b1;
                end else if (acc.rvalid) begin
                    wait_d = 1'b0;
                    if (acc.rdata[0]) begin
                        state_d = ST_ARD;
                    end else begin
                        poll_d = poll_inc;
                        if (poll_inc == POLL_LIMIT_W) begin
                            err_d   = 1'b1;
                            state_d = ST_CLR_LAST;
                        end
                    end
                end
            end

            // The output window is four words wide; k wraps over it.
            ST_ARD: begin
                if (!wait_q) begin
                    acc.req  = 1'b1;
                    acc.be   = BE_ALL;
                    acc.addr = ACC_BASE + OFF_OUT_BASE + {28'd0, k_q[1:0], 2'b00};
                    if (acc.gnt) wait_d = 1'b1;
                end else if (acc.rvalid) begin
                    wait_d  = 1'b0;
                    buf_d   = acc.rdata;
                    state_d = ST_MWR;
                end
            end

            ST_MWR: begin
                if (!wait_q) begin
                    mem.req   = 1'b1;
                    mem.we    = 1'b1;
                    mem.be    = BE_ALL;
                    mem.addr  = dst_q + {14'd0, k_q, 2'b00};
                    mem.wdata = buf_q;
                    if (mem.gnt) wait_d = 1'b1;
                end else if (mem.rvalid) begin
                    wait_d  = 1'b0;
                    k_d     = k_inc;
                    state_d = (k_inc == OUT_WORDS_W) ? ST_CLR_LAST : ST_ARD;
                end
            end

            ST_CLR_LAST: begin
                acc.req   = 1'b1;
                acc.we    = 1'b1;
                acc.be    = BE_ALL;
                acc.addr  = ACC_BASE + OFF_IS_LAST;
                acc.wdata = 32'd0;
                if (acc.gnt) state_d = ST_CLR_RV;
            end

            ST_CLR_RV: begin
                acc.req   = 1'b1;
                acc.we    = 1'b1;
                acc.be    = BE_ALL;
                acc.addr  = ACC_BASE + OFF_R_VALID;
                acc.wdata = 32'd0;
                if (acc.gnt) state_d = ST_DONE;
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            i_q     <= 16'd0;
            k_q     <= 16'd0;
            poll_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            i_q     <= i_d;
            k_q     <= k_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
        end
    end

    // Command fields and the word buffer are only consumed outside IDLE, so they carry no reset.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        dst_q  <= dst_d;
        n_q    <= n_d;
        last_q <= last_d;
        buf_q  <= buf_d;
    end

endmodule

// File: tb/tb_lstm_stream_master.sv
// Bench for lstm_stream_master: randomly stalling memory and accelerator slaves,
// a transaction-list reference model and a table of command vectors.
module tb_lstm_stream_master;
    import lstm_acc_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          PL   = 4;
    localparam int          OUTW = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    typedef struct {
        int n;
        bit lst;
        int wvz;
        int stl;
        bit wrap;
        bit poke;
        bit exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] dst_addr_i;
    logic [15:0] n_words_i;
    logic        last_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    lstm_stream_master_if mem_bus ();
    lstm_stream_master_if acc_bus ();

    lstm_stream_master #(
        .ACC_BASE  (BASE),
        .OUT_WORDS (OUTW),
        .POLL_LIMIT(PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i),
        .n_words_i (n_words_i),
        .last_i    (last_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .mem       (mem_bus),
        .acc       (acc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- slave models ----------------
    int          max_stall = 0;
    int          wv_zeros  = 0;
    int          wv_cnt    = 0;
    int          out_idx   = 0;
    logic [31:0] out_vals[OUTW];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] acc_junk;

    int          m_stall, a_stall, m_rwait, a_rwait;
    bit          m_pend, a_pend;
    logic [31:0] m_rdata, a_rdata;

    assign mem_bus.gnt    = mem_bus.req && (m_stall == 0) && !m_pend;
    assign mem_bus.rvalid = m_pend && (m_rwait == 0);
    assign mem_bus.rdata  = m_rdata;
    assign acc_bus.gnt    = acc_bus.req && (a_stall == 0) && !a_pend;
    assign acc_bus.rvalid = a_pend && (a_rwait == 0);
    assign acc_bus.rdata  = a_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stall <= 0; m_pend <= 1'b0; m_rwait <= 0; m_rdata <= 32'h0;
        end else if (mem_bus.req && mem_bus.gnt) begin
            m_pend  <= 1'b1;
            m_rwait <= $urandom_range(max_stall, 0);
            m_stall <= $urandom_range(max_stall, 0);
            if (mem_bus.we) begin
                mem_arr[mem_bus.addr] = mem_bus.wdata;
                m_rdata <= $urandom();
            end else begin
                m_rdata <= mem_arr.exists(mem_bus.addr) ? mem_arr[mem_bus.addr] : 32'hBAD0_0000;
            end
        end else begin
            if (mem_bus.req && m_stall > 0) m_stall <= m_stall - 1;
            if (m_pend) begin
                if (m_rwait == 0) m_pend <= 1'b0;
                else m_rwait <= m_rwait - 1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_stall <= 0; a_pend <= 1'b0; a_rwait <= 0; a_rdata <= 32'h0;
        end else if (acc_bus.req && acc_bus.gnt) begin
            a_stall <= $urandom_range(max_stall, 0);
            if (!acc_bus.we) begin
                a_pend  <= 1'b1;
                a_rwait <= $urandom_range(max_stall, 0);
                acc_junk = $urandom();
                if (acc_bus.addr == BASE + OFF_W_VALID) begin
                    a_rdata <= {acc_junk[31:1], (wv_zeros >= 0) && (wv_cnt >= wv_zeros)};
                    wv_cnt++;
                end else if (out_idx < OUTW) begin
                    a_rdata <= out_vals[out_idx];
                    out_idx++;
                end else begin
                    a_rdata <= acc_junk;
                end
            end
        end else begin
            if (acc_bus.req && a_stall > 0) a_stall <= a_stall - 1;
            if (a_pend) begin
                if (a_rwait == 0) a_pend <= 1'b0;
                else a_rwait <= a_rwait - 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    xact_t got_acc[$], got_mem[$], exp_acc[$], exp_mem[$];
    int    done_cnt = 0;
    bit    m_hold = 1'b0, a_hold = 1'b0;
    xact_t m_prev, a_prev;

    always @(negedge clk) begin
        if (!rst) begin
            m_hold = 1'b0;
            a_hold = 1'b0;
        end else begin
            if (m_hold) begin
                chk("mem req held", {61'd0, mem_bus.req, mem_bus.we, mem_bus.be == BE_ALL}, {61'd0, 1'b1, m_prev.we, 1'b1});
                chk("mem addr held", {32'd0, mem_bus.addr}, {32'd0, m_prev.addr});
                chk("mem wdata held", {32'd0, mem_bus.wdata}, {32'd0, m_prev.data});
            end
            if (a_hold) begin
                chk("acc req held", {61'd0, acc_bus.req, acc_bus.we, acc_bus.be == BE_ALL}, {61'd0, 1'b1, a_prev.we, 1'b1});
                chk("acc addr held", {32'd0, acc_bus.addr}, {32'd0, a_prev.addr});
                chk("acc wdata held", {32'd0, acc_bus.wdata}, {32'd0, a_prev.data});
            end
            if (mem_bus.req && mem_bus.gnt) begin
                got_mem.push_back({mem_bus.we, mem_bus.addr, mem_bus.we ? mem_bus.wdata : 32'h0});
                chk("mem be", {60'd0, mem_bus.be}, {60'd0, BE_ALL});
            end
            if (acc_bus.req && acc_bus.gnt) begin
                got_acc.push_back({acc_bus.we, acc_bus.addr, acc_bus.we ? acc_bus.wdata : 32'h0});
                chk("acc be", {60'd0, acc_bus.be}, {60'd0, BE_ALL});
            end
            m_hold = mem_bus.req && !mem_bus.gnt;
            m_prev = {mem_bus.we, mem_bus.addr, mem_bus.wdata};
            a_hold = acc_bus.req && !acc_bus.gnt;
            a_prev = {acc_bus.we, acc_bus.addr, acc_bus.wdata};
            if (done_o) done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    // Expected transaction lists for one command, written straight from the command rules.
    task automatic build_exp(input int n, input bit lst, input int wvz,
                             input logic [31:0] sa, input logic [31:0] da,
                             input logic [31:0] words[$]);
        int  polls;
        bit  tmo;
        exp_acc.delete();
        exp_mem.delete();
        exp_acc.push_back({1'b1, BASE + 32'h58, 32'd1});
        for (int i = 0; i < n; i++) begin
            exp_mem.push_back({1'b0, sa + 32'(4 * i), 32'h0});
            exp_acc.push_back({1'b1, BASE + 32'h04, words[i]});
        end
        if (lst) begin
            exp_acc.push_back({1'b1, BASE + 32'h5C, 32'd1});
            tmo   = (wvz < 0) || (wvz >= PL);
            polls = tmo ? PL : wvz + 1;
            for (int p = 0; p < polls; p++) exp_acc.push_back({1'b0, BASE + 32'h64, 32'h0});
            if (!tmo) begin
                for (int k = 0; k < OUTW; k++) begin
                    exp_acc.push_back({1'b0, BASE + 32'h48 + 32'(4 * (k % 4)), 32'h0});
                    exp_mem.push_back({1'b1, da + 32'(4 * k), out_vals[k]});
                end
            end
            exp_acc.push_back({1'b1, BASE + 32'h5C, 32'd0});
        end
        exp_acc.push_back({1'b1, BASE + 32'h58, 32'd0});
    endtask

    task automatic cmp_lists(input string tag);
        for (int j = 0; j < exp_acc.size() && j < got_acc.size(); j++) begin
            chk($sformatf("%s acc%0d addr", tag, j), {31'd0, got_acc[j].we, got_acc[j].addr}, {31'd0, exp_acc[j].we, exp_acc[j].addr});
            chk($sformatf("%s acc%0d data", tag, j), {32'd0, got_acc[j].data}, {32'd0, exp_acc[j].data});
        end
        for (int j = 0; j < exp_mem.size() && j < got_mem.size(); j++) begin
            chk($sformatf("%s mem%0d addr", tag, j), {31'd0, got_mem[j].we, got_mem[j].addr}, {31'd0, exp_mem[j].we, exp_mem[j].addr});
            chk($sformatf("%s mem%0d data", tag, j), {32'd0, got_mem[j].data}, {32'd0, exp_mem[j].data});
        end
    endtask

    task automatic run_cmd(input string tag, input int n, input bit lst, input int wvz, input int stl,
                           input logic [31:0] sa, input logic [31:0] da, input bit poke, input bit exp_err);
        logic [31:0] words[$];
        logic [31:0] w;
        int          cyc;
        max_stall = stl;
        wv_zeros  = wvz;
        wv_cnt    = 0;
        out_idx   = 0;
        for (int k = 0; k < OUTW; k++) out_vals[k] = $urandom();
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            words.push_back(w);
            mem_arr[sa + 32'(4 * i)] = w;
        end
        build_exp(n, lst, wvz, sa, da, words);
        got_acc.delete();
        got_mem.delete();
        done_cnt = 0;

        @(negedge clk);
        src_addr_i = sa; dst_addr_i = da; n_words_i = 16'(n); last_i = lst; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, " busy after start"}, {63'd0, busy_o}, 64'd1);
        chk({tag, " err cleared"}, {63'd0, err_o}, 64'd0);
        if (poke) begin
            // Conflicting command presented while busy must be ignored.
            src_addr_i = ~sa; n_words_i = 16'd7; last_i = ~lst; start_i = 1'b1;
            repeat (2) @(negedge clk);
            start_i = 1'b0;
        end
        cyc = 0;
        while (!done_o && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done seen"}, {63'd0, done_o}, 64'd1);
        chk({tag, " busy at done"}, {63'd0, busy_o}, 64'd0);
        chk({tag, " acc count"}, 64'(got_acc.size()), 64'(exp_acc.size()));
        chk({tag, " mem count"}, 64'(got_mem.size()), 64'(exp_mem.size()));
        if (poke) begin
            // A start presented in the DONE cycle must also be ignored.
            start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk({tag, " idle after"}, {63'd0, busy_o}, 64'd0);
        chk({tag, " done once"}, 64'(done_cnt), 64'd1);
        chk({tag, " err"}, {63'd0, err_o}, {63'd0, exp_err});
        cmp_lists(tag);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem req"}, {63'd0, mem_bus.req}, 64'd0);
        chk({tag, " mem we/be"}, {59'd0, mem_bus.we, mem_bus.be}, 64'd0);
        chk({tag, " mem addr"}, {32'd0, mem_bus.addr}, 64'd0);
        chk({tag, " mem wdata"}, {32'd0, mem_bus.wdata}, 64'd0);
        chk({tag, " acc req"}, {63'd0, acc_bus.req}, 64'd0);
        chk({tag, " acc addr"}, {32'd0, acc_bus.addr}, 64'd0);
        chk({tag, " busy/done/err"}, {61'd0, busy_o, done_o, err_o}, 64'd0);
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{3, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{2, 1'b1,  2, 0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{0, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{0, 1'b1,  0, 0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{5, 1'b1,  3, 5, 1'b0, 1'b0, 1'b0};
        vt[6] = '{4, 1'b0,  0, 5, 1'b1, 1'b0, 1'b0};
        vt[7] = '{2, 1'b1, -1, 5, 1'b0, 1'b0, 1'b1};
        vt[8] = '{6, 1'b1,  1, 5, 1'b1, 1'b1, 1'b0};
        vt[9] = '{3, 1'b1,  4, 2, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; n_words_i = '0; last_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("post reset");

        for (int v = 0; v < 10; v++) begin
            run_cmd($sformatf("vec%0d", v), vt[v].n, vt[v].lst, vt[v].wvz, vt[v].stl,
                    vt[v].wrap ? 32'hFFFF_FFF8 : 32'h0001_0000 + 32'(v * 256),
                    vt[v].wrap ? 32'hFFFF_FFF0 : 32'h0008_0000 + 32'(v * 256),
                    vt[v].poke, vt[v].exp_err);
        end

        // Reset asserted while the master waits on a memory read.
        begin
            int cyc;
            max_stall = 3; wv_zeros = 0; wv_cnt = 0; out_idx = 0;
            for (int i = 0; i < 4; i++) mem_arr[32'h0002_0000 + 32'(4 * i)] = $urandom();
            @(negedge clk);
            src_addr_i = 32'h0002_0000; dst_addr_i = 32'h0009_0000; n_words_i = 16'd4; last_i = 1'b1; start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            cyc = 0;
            while (!(mem_bus.req && !mem_bus.we) && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("rst-mrd reached MRD", {63'd0, mem_bus.req}, 64'd1);
            rst = 1'b0;
            @(negedge clk);
            chk_quiet("rst-mrd");
            @(negedge clk);
            rst = 1'b1;
        end
        run_cmd("after rst", 4, 1'b1, 1, 3, 32'h0003_0000, 32'h000A_0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
